mm_mac_engine: RTL

//  Parametrised unsigned matrix-multiply engine: RES[MxP] = (A[MxN] * B[NxP]) >> SHIFT.

---
 rtl/mm_mac_engine.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mm_mac_engine.sv
// Unsigned matrix-multiply engine: RES = (A * B) >> SHIFT, with optional saturation.
// Streams A/B out of synchronous-read BRAMs and writes one result element every N+2 cycles.
module mm_mac_engine #(
  parameter int WIDTH          = 8,
  parameter int M              = 64,
  parameter int N              = 8,
  parameter int P              = 4,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 9,
  parameter int RES_depth_bits = 9,
  parameter int SHIFT          = 8,
  parameter int SATURATE       = 0
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      Start,
  output logic                      Done,
  output logic                      Busy,
  output logic                      A_read_en,
  output logic [A_depth_bits-1:0]   A_read_address,
  input  logic [WIDTH-1:0]          A_read_data_out,
  output logic                      B_read_en,
  output logic [B_depth_bits-1:0]   B_read_address,
  input  logic [WIDTH-1:0]          B_read_data_out,
  output logic                      RES_write_en,
  output logic [RES_depth_bits-1:0] RES_write_address,
  output logic [WIDTH-1:0]          RES_write_data_in
);

  localparam int ACC_W = 2*WIDTH + $clog2(N) + 1;
  localparam int JW    = $clog2(N+1);
  localparam int KW    = $clog2(P+1);
  localparam int IW    = $clog2(M+1);

  typedef enum logic [2:0] {IDLE, ISSUE, TAIL, WRITE, DONE} state_t;

  state_t                    state, state_nx;
  logic [JW-1:0]             j;
  logic [KW-1:0]             k;
  logic [IW-1:0]             i;
  logic [A_depth_bits-1:0]   a_row, a_ptr;
  logic [B_depth_bits-1:0]   b_ptr;
  logic [RES_depth_bits-1:0] res_ptr;
  logic [ACC_W-1:0]          acc, scaled;
  logic [2*WIDTH-1:0]        prod;
  logic [WIDTH-1:0]          res_val;
  logic                      last_j, last_k, last_elem;

  assign prod      = (2*WIDTH)'(A_read_data_out) * (2*WIDTH)'(B_read_data_out);
  assign scaled    = acc >> SHIFT;
  assign last_j    = (j == JW'(N-1));
  assign last_k    = (k == KW'(P-1));
  assign last_elem = last_k && (i == IW'(M-1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res_val = scaled[WIDTH-1:0];
    if (SATURATE != 0 && scaled > ACC_W'({WIDTH{1'b1}})) res_val = '1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = ISSUE;
      ISSUE:   if (last_j) state_nx = TAIL;
      TAIL:    state_nx = WRITE;
      WRITE:   state_nx = last_elem ? DONE : ISSUE;
      DONE:    if (!Start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      j       <= '0;
      k       <= '0;
      i       <= '0;
      a_row   <= '0;
      a_ptr   <= '0;
      b_ptr   <= '0;
      res_ptr <= '0;
      acc     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (Start) begin
          j       <= '0;
          k       <= '0;
          i       <= '0;
          a_row   <= '0;
          a_ptr   <= '0;
          b_ptr   <= '0;
          res_ptr <= '0;
          acc     <= '0;
        end
        ISSUE: begin
          // Data returning this cycle belongs to the previous j; the first cycle has none.
          if (j != '0) acc <= acc + ACC_W'(prod);
          j     <= j + 1'b1;
          a_ptr <= a_ptr + 1'b1;
          b_ptr <= b_ptr + B_depth_bits'(P);
        end
        TAIL: acc <= acc + ACC_W'(prod);
        WRITE: begin
          acc     <= '0;
          j       <= '0;
          res_ptr <= res_ptr + 1'b1;
          if (last_k) begin
            k     <= '0;
            i     <= i + 1'b1;
            a_row <= a_row + A_depth_bits'(N);
            a_ptr <= a_row + A_depth_bits'(N);
            b_ptr <= '0;
          end else begin
            k     <= k + 1'b1;
            a_ptr <= a_row;
            b_ptr <= B_depth_bits'(k) + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy              = (state == ISSUE) || (state == TAIL) || (state == WRITE);
  assign Done              = (state == DONE);
  assign A_read_en         = (state == ISSUE);
  assign B_read_en         = (state == ISSUE);
  assign A_read_address    = A_read_en ? a_ptr : '0;
  assign B_read_address    = B_read_en ? b_ptr : '0;
  assign RES_write_en      = (state == WRITE);
  assign RES_write_address = RES_write_en ? res_ptr : '0;
  assign RES_write_data_in = RES_write_en ? res_val : '0;

endmodule
